// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester and register-file write bundle for regfile_write_arbiter
//
// Purpose: groups the per-source write requests, the stall control and the
//          registered register-file write port into one bundle.
// Signals:
//   req_valid  NUM_REQ         requester i holds a write
//   req_addr   NUM_REQ*ADDR_W  destination register, slice i = [i*ADDR_W +: ADDR_W]
//   req_data   NUM_REQ*DATA_W  write data, slice i = [i*DATA_W +: DATA_W]
//   req_ready  NUM_REQ         one-hot grant back to the requesters
//   stall      1               1 = no grants this cycle
//   rf_we      1               register-file write enable
//   rf_waddr   ADDR_W          register-file destination
//   rf_wdata   DATA_W          register-file write data
//   rf_wsrc    SRC_W           index of the source of the current write
// Modports: slave = arbiter side, master = requesters / register file side.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      stall;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [SRC_W-1:0]          rf_wsrc;

  modport slave (
    input  req_valid, req_addr, req_data, stall,
    output req_ready, rf_we, rf_waddr, rf_wdata, rf_wsrc
  );

  modport master (
    output req_valid, req_addr, req_data, stall,
    input  req_ready, rf_we, rf_waddr, rf_wdata, rf_wsrc
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the register-file write port
//
// Purpose: grants one of NUM_REQ writeback sources per cycle (round-robin from
//          a rotating priority pointer) and registers the winning address/data
//          onto the register-file write port one cycle after the handshake.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of regfile_write_arbiter_if
//            in : req_valid, req_addr, req_data, stall
//            out: req_ready (combinational one-hot grant),
//                 rf_we, rf_waddr, rf_wdata, rf_wsrc (registered)
// Configuration macro: RF_R0_DISCARD_EN - writes to register 0 complete the
//   handshake and advance the pointer but never raise rf_we.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  regfile_write_arbiter_if.slave   bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SRC_W:0] NUM_REQ_W = (SRC_W + 1)'(NUM_REQ);

  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [SRC_W-1:0]   wsrc_q, wsrc_d;

  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W:0]     cand;
  logic [SRC_W:0]     ptr_inc;
  logic [NUM_REQ-1:0] ready;
  logic [ADDR_W-1:0]  grant_addr;
  logic [DATA_W-1:0]  grant_data;

  // Walk the requesters starting at ptr_q and wrapping; the first valid one
  // wins. cand carries one extra bit so the wrap compare cannot overflow.
  // rst_n gates the search so req_ready is low for the whole reset.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (SRC_W + 1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!grant_found && !bus.stall && rst_n && bus.req_valid[cand[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (grant_found) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign grant_addr = bus.req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
  assign grant_data = bus.req_data[int'(grant_idx) * DATA_W +: DATA_W];

  // Next state: a grant captures the winner and moves priority past it;
  // otherwise the write port deasserts we and holds its last contents.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wsrc_d  = wsrc_q;
    ptr_d   = ptr_q;
    ptr_inc = '0;
    if (grant_found) begin
      waddr_d = grant_addr;
      wdata_d = grant_data;
      wsrc_d  = grant_idx;
`ifdef RF_R0_DISCARD_EN
      // r0 is hard-wired zero: accept the write but never enable it.
      we_d    = (grant_addr != '0);
`else
      we_d    = 1'b1;
`endif
      ptr_inc = {1'b0, grant_idx} + (SRC_W + 1)'(1);
      if (ptr_inc >= NUM_REQ_W) begin
        ptr_inc = '0;
      end
      ptr_d   = ptr_inc[SRC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wsrc_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wsrc_q  <= wsrc_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rf_we     = we_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.rf_wsrc   = wsrc_q;
endmodule
